// File: rtl/uart_tx_frame_sched.sv
// uart_tx_frame_sched: round-robin scheduler serializing result/error frames (header, payload, CRC-8) onto uart_tx
module uart_tx_frame_sched #(
  parameter logic [7:0] ERR_HDR  = 8'hEE,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_res_valid,
  input  logic [7:0]  i_res_cmd,
  input  logic [47:0] i_res_sin,
  input  logic [47:0] i_res_cos,
  output logic        o_res_ready,
  input  logic        i_err_valid,
  input  logic [7:0]  i_err_code,
  output logic        o_err_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_byte_valid,
  input  logic        i_tx_ready,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CRC} state_t;
  state_t      state_q, state_d;
  logic        last_err_q, last_err_d;
  logic        is_err_q, is_err_d;
  logic        done_q, done_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  crc_q, crc_d;
  logic [95:0] pay_q, pay_d;
  logic        grant_err, grant_res, accept;
  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    return r;
  endfunction
  always_comb begin
    grant_err       = state_q == IDLE && !i_rst && i_err_valid && (!i_res_valid || !last_err_q);
    grant_res       = state_q == IDLE && !i_rst && i_res_valid && !grant_err;
    o_err_ready     = grant_err;
    o_res_ready     = grant_res;
    o_busy          = state_q != IDLE;
    o_tx_byte_valid = state_q != IDLE && !done_q;
    o_tx_byte       = state_q == HDR ? hdr_q :
                      state_q == PAYLOAD ? pay_q[95:88] :
                      (state_q == CRC && !done_q) ? crc_q : 8'h00;
    accept          = o_tx_byte_valid && i_tx_ready;
    state_d         = state_q;
    last_err_d      = last_err_q;
    is_err_d        = is_err_q;
    done_d          = done_q;
    cnt_d           = cnt_q;
    hdr_d           = hdr_q;
    crc_d           = crc_q;
    pay_d           = pay_q;
    case (state_q)
      IDLE: if (grant_err || grant_res) begin
        state_d    = HDR;
        last_err_d = grant_err;
        is_err_d   = grant_err;
        hdr_d      = grant_err ? ERR_HDR : i_res_cmd;
        pay_d      = grant_err ? {i_err_code, 88'h0} : {i_res_sin, i_res_cos};
        crc_d      = 8'h00;
        cnt_d      = 4'd0;
      end
      HDR: if (accept) begin
        crc_d   = crc8_upd(crc_q, o_tx_byte);
        state_d = PAYLOAD;
      end
      PAYLOAD: if (accept) begin
        crc_d   = crc8_upd(crc_q, o_tx_byte);
        pay_d   = pay_q << 8;
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == (is_err_q ? 4'd0 : 4'd11) ? CRC : PAYLOAD;
      end
      // done_q marks the one dead cycle after the CRC byte before returning to IDLE
      CRC: begin
        done_d  = done_q ? 1'b0 : accept;
        state_d = done_q ? IDLE : CRC;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      last_err_q <= 1'b0;
      is_err_q   <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 4'd0;
      hdr_q      <= 8'h00;
      crc_q      <= 8'h00;
      pay_q      <= 96'h0;
    end else begin
      state_q    <= state_d;
      last_err_q <= last_err_d;
      is_err_q   <= is_err_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      pay_q      <= pay_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// tb_uart_tx_frame_sched: directed checks of arbitration, framing, CRC, stalls and mid-frame reset
module tb_uart_tx_frame_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0, err_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]  res_cmd = 8'h00, err_code = 8'h00;
  logic [47:0] res_sin = 48'h0, res_cos = 48'h0;
  logic        res_ready, err_ready, tx_valid, busy;
  logic [7:0]  tx_byte;
  int          n_chk = 0, n_fail = 0;
  int          busy_cnt = 0, err_rdy_cnt = 0, stalls = 0, zeros = 0;
  bit          rand_en = 1'b0, stall_q = 1'b0;
  logic [7:0]  stall_byte;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  uart_tx_frame_sched dut (
    .i_clk(clk), .i_rst(rst),
    .i_res_valid(res_valid), .i_res_cmd(res_cmd), .i_res_sin(res_sin), .i_res_cos(res_cos),
    .o_res_ready(res_ready),
    .i_err_valid(err_valid), .i_err_code(err_code), .o_err_ready(err_ready),
    .o_tx_byte(tx_byte), .o_tx_byte_valid(tx_valid), .i_tx_ready(tx_ready), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  function automatic logic [7:0] crc_ref(input logic [7:0] f[$]);
    logic [7:0] c = 8'h00;
    foreach (f[k])
      for (int i = 7; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ f[k][i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
  task automatic add_err(input logic [7:0] code);
    logic [7:0] f[$];
    f = '{8'hEE, code};
    f.push_back(crc_ref(f));
    foreach (f[k]) exp_q.push_back(f[k]);
  endtask
  task automatic add_res(input logic [7:0] cmd, input logic [47:0] s, input logic [47:0] c);
    logic [7:0] f[$];
    logic [95:0] p;
    p = {s, c};
    f.push_back(cmd);
    for (int i = 11; i >= 0; i--) f.push_back(p[i*8 +: 8]);
    f.push_back(crc_ref(f));
    foreach (f[k]) exp_q.push_back(f[k]);
  endtask
  always @(negedge clk) begin
    if (stall_q) chk("stall_hold", {tx_valid, tx_byte}, {1'b1, stall_byte});
    if (busy) chk("rdy_busy", {res_ready, err_ready}, 2'b00);
    if (tx_valid && tx_ready && !rst) got.push_back(tx_byte);
    stall_q    = tx_valid && !tx_ready && !rst;
    stall_byte = tx_byte;
    if (stall_q) stalls++;
    if (busy) busy_cnt++;
    if (err_ready) err_rdy_cnt++;
  end
  initial forever begin
    @(posedge clk); #1;
    if (rand_en) begin
      if (zeros >= 5 || $urandom_range(0, 1) == 1) begin tx_ready = 1'b1; zeros = 0; end
      else begin tx_ready = 1'b0; zeros++; end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_rdy(input bit err, input string tag);
    int n = 0;
    @(negedge clk);
    while ((err ? !err_ready : !res_ready) && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_grant_to"}, n < 200, 1);
    chk({tag, "_grant_busy"}, busy, 0);
    chk({tag, "_one_rdy"}, err ? res_ready : err_ready, 0);
    tick();
    if (err) err_valid = 1'b0; else res_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_idle_to"}, n < 400, 1);
    tick();
  endtask
  task automatic cmp(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_b%0d", tag, i), i < got.size() ? got[i] : 8'hxx, exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    int n0, n;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", {res_ready, err_ready}, 0);
    tick();
    // single error frame
    busy_cnt = 0; err_rdy_cnt = 0;
    err_code = 8'h01; err_valid = 1'b1;
    wait_rdy(1, "err1");
    wait_idle("err1");
    chk("err1_busy_cycles", busy_cnt, 4);
    chk("err1_rdy_cycles", err_rdy_cnt, 1);
    exp_q = '{8'hEE, 8'h01, 8'h92};
    cmp("err1");
    // single result frame
    res_cmd = 8'h10; res_sin = 48'h0123456789AB; res_cos = 48'hCDEF01234567; res_valid = 1'b1;
    wait_rdy(0, "res1");
    wait_idle("res1");
    add_res(8'h10, 48'h0123456789AB, 48'hCDEF01234567);
    chk("res1_b1_const", exp_q[1], 8'h01);
    cmp("res1");
    // tie: last grant was result, so error wins, then result
    err_code = 8'h7F; res_cmd = 8'h22; res_sin = 48'hFFFF00001111; res_cos = 48'h8000000000FF;
    err_valid = 1'b1; res_valid = 1'b1;
    wait_rdy(1, "tie1e");
    wait_rdy(0, "tie1r");
    wait_idle("tie1");
    add_err(8'h7F);
    add_res(8'h22, 48'hFFFF00001111, 48'h8000000000FF);
    cmp("tie1");
    err_code = 8'hA5; err_valid = 1'b1; res_valid = 1'b1;
    wait_rdy(1, "tie2");
    res_valid = 1'b0;
    wait_idle("tie2");
    add_err(8'hA5);
    cmp("tie2");
    // random stalls on tx_ready
    stalls = 0;
    res_cmd = 8'h10; res_sin = 48'h0123456789AB; res_cos = 48'hCDEF01234567; res_valid = 1'b1;
    rand_en = 1'b1;
    wait_rdy(0, "stall");
    wait_idle("stall");
    rand_en = 1'b0; tx_ready = 1'b1;
    chk("stall_seen", stalls > 0, 1);
    add_res(8'h10, 48'h0123456789AB, 48'hCDEF01234567);
    cmp("stall");
    // request held during a frame; operands captured at grant only
    err_code = 8'h33; err_valid = 1'b1;
    wait_rdy(1, "held_e");
    res_cmd = 8'h42; res_sin = 48'h112233445566; res_cos = 48'h778899AABBCC; res_valid = 1'b1;
    wait_rdy(0, "held_r");
    res_cmd = 8'hFF; res_sin = 48'h0; res_cos = 48'hFFFFFFFFFFFF;
    wait_idle("held");
    add_err(8'h33);
    add_res(8'h42, 48'h112233445566, 48'h778899AABBCC);
    cmp("held");
    // reset mid-payload
    res_cmd = 8'h55; res_sin = 48'hDEADBEEF0102; res_cos = 48'h030405060708; res_valid = 1'b1;
    wait_rdy(0, "abort");
    n = 0;
    @(negedge clk);
    while (got.size() < 6 && n < 100) begin @(negedge clk); n++; end
    chk("abort_reach_to", n < 100, 1);
    tick();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_byte", tx_byte, 0);
    n0 = got.size();
    repeat (20) @(negedge clk);
    chk("abort_no_more", got.size(), n0);
    chk("abort_short", n0 < 14, 1);
    tick();
    got.delete();
    err_code = 8'h5A; err_valid = 1'b1;
    wait_rdy(1, "post");
    wait_idle("post");
    add_err(8'h5A);
    cmp("post");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
